// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: controller state encoding and default width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder; the single bit-slice reused on every cycle of a serial add.
module fulladder (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one fulladder, LSB first, start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to let the sub input select a - b (c_out=1 means no borrow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             fa_sum;
    logic             fa_cout;
    logic             unused_ok;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + 1; the forced carry-in replaces c_in.
    assign b_load     = sub ? ~b_in : b_in;
    assign carry_load = sub ? 1'b1  : c_in;
    assign unused_ok  = sum_sh_q[0];
`else
    assign b_load     = b_in;
    assign carry_load = c_in;
    assign unused_ok  = ^{sum_sh_q[0], sub};
`endif

    fulladder u_fa (
        .sum  (fa_sum),
        .c_out(fa_cout),
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .c_in (carry_q)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        sum_out_d = sum_out_q;
        carry_d   = carry_q;
        c_out_d   = c_out_q;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                // Outputs are loaded only with the completed word, never a partial one.
                if (cnt_q == CNT_LAST) begin
                    sum_out_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
                    c_out_d   = fa_cout;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            sum_out_q <= '0;
            carry_q   <= 1'b0;
            c_out_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            sum_out_q <= sum_out_d;
            carry_q   <= carry_d;
            c_out_q   <= c_out_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign sum_out = sum_out_q;
    assign c_out   = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8) with a result scoreboard.
// Subtraction expectations follow SERIAL_ADDER_SUB_EN when the bench is built with it.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         c_out;

    int total = 0;
    int bad   = 0;

    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .c_in   (c_in),
        .sub    (sub),
        .busy   (busy),
        .done   (done),
        .sum_out(sum_out),
        .c_out  (c_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        logic [W-1:0] nb;
        nb = ~b;
`ifdef SERIAL_ADDER_SUB_EN
        if (s) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
`endif
        if (s && nb == b) return '0;
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered on the negedge after the accepting edge; returns on the negedge after done.
    task automatic wait_result(input string tag, input int pulse_at, input bit hold);
        logic [W:0] e;
        int  n;
        bit  seen;
        n    = 1;
        seen = 1'b0;
        for (int i = 0; i < 4 * W && !seen; i++) begin
            if (n == pulse_at) begin
                start = 1'b1;
                a_in  = 8'hAA;
                b_in  = 8'h55;
            end else begin
                start = hold;
            end
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) n++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, n, W);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (seen) begin
            check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
            check({tag, "_sum"}, 32'(sum_out), 32'(e[W-1:0]));
            check({tag, "_cout"}, 32'(c_out), 32'(e[W]));
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
            check({tag, "_sum_held"}, 32'(sum_out), 32'(e[W-1:0]));
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input int pulse_at, input bit hold);
        a_in  = a;
        b_in  = b;
        c_in  = c;
        sub   = s;
        start = 1'b1;
        exp_q.push_back(model(a, b, c, s));
        @(negedge clk);
        check({tag, "_accept"}, 32'(busy), 32'd1);
        if (!hold) begin
            start = 1'b0;
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            c_in  = 1'($urandom);
            sub   = 1'($urandom);
        end
        wait_result(tag, pulse_at, hold);
    endtask

    initial begin
        int  done_cnt;
        bit  rebusy;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        c_in  = 1'b0;
        sub   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum_out), 32'h00);
        check("rst_cout", 32'(c_out), 32'd0);
        @(negedge clk);

        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
        run_op("ignore_start", 8'h21, 8'h13, 1'b0, 1'b0, 3, 1'b0);

        // start held high through done: a second operation must follow on its own.
        run_op("hold_first", 8'h81, 8'h90, 1'b0, 1'b0, 0, 1'b1);
        exp_q.push_back(model(8'h81, 8'h90, 1'b0, 1'b0));
        rebusy = 1'b0;
        for (int i = 0; i < 2 && !rebusy; i++) begin
            @(negedge clk);
            if (busy) rebusy = 1'b1;
        end
        check("hold_rebusy", 32'(rebusy), 32'd1);
        if (rebusy) wait_result("hold_second", 0, 1'b0);
        else void'(exp_q.pop_front());
        start = 1'b0;

        // Abort mid-run with an asynchronous reset between clock edges.
        a_in  = 8'h12;
        b_in  = 8'h34;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_accept", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum_out), 32'h00);
        check("abort_cout", 32'(c_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        run_op("after_abort", 8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);

        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 0, 1'b0);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b0);
        run_op("nosub_10_01_c", 8'h10, 8'h01, 1'b1, 1'b0, 0, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
